ptos_tx_sequencer: RTL and testbench

//  Sequences an external parallel-to-serial shifter (load/shift-enable style) for serial transmit.
//  Two byte requesters share the shifter through a round-robin arbiter.

---
 rtl/ptos_tx_sequencer.sv | 161 ++++++++++++++++
 tb/tb_ptos_tx_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptos_tx_sequencer.sv
// ptos_tx_sequencer
// Drives an external load/shift-enable parallel-to-serial shifter for serial transmit.
// Two requesters share the shifter through a round-robin arbiter; each accepted word
// takes one load cycle and WIDTH frame cycles (MSB first), then an optional idle gap.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a requester; ready offered to the arbitration winner
// S_LOAD  | sh_load strobe, shifter captures sh_data
// S_SHIFT | WIDTH frame cycles, shifter sOut carries sh_data[WIDTH-1-count]
// S_GAP   | GAP_CYCLES quiet cycles before returning to S_IDLE
module ptos_tx_sequencer #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic             Clock,
    input  logic             rst,
    input  logic             i_req0_valid,
    input  logic [WIDTH-1:0] i_req0_data,
    output logic             o_req0_ready,
    input  logic             i_req1_valid,
    input  logic [WIDTH-1:0] i_req1_data,
    output logic             o_req1_ready,
    output logic [WIDTH-1:0] o_sh_data,
    output logic             o_sh_load,
    output logic             o_sh_en,
    output logic             o_sh_sIn,
    output logic             o_frame,
    output logic             o_grant_id,
    output logic             o_busy,
    output logic             o_done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_bit_cnt;
    logic [CW-1:0]    w_bit_cnt_nxt;
    logic [GW-1:0]    r_gap_cnt;
    logic [GW-1:0]    w_gap_cnt_nxt;
    logic [WIDTH-1:0] r_sh_data;
    logic             r_grant_id;
    logic             r_last_grant;
    logic             r_done;

    logic             w_idle;
    logic             w_win1;
    logic             w_take0;
    logic             w_take1;
    logic             w_accept;
    logic             w_last_bit;

    // Arbitration: a lone requester wins; on a tie the one not granted last wins.
    // Ready is withheld while reset is asserted so no word is consumed by a reset edge.
    always_comb begin
        w_idle     = (r_state == S_IDLE);
        w_win1     = i_req1_valid && (!i_req0_valid || !r_last_grant);
        w_take1    = w_idle && rst && w_win1;
        w_take0    = w_idle && rst && i_req0_valid && !w_win1;
        w_accept   = w_take0 || w_take1;
        w_last_bit = (r_bit_cnt == LAST_BIT);
    end

    // FSM state, bit counter and gap down-counter registers.
    always_ff @(posedge Clock) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
        end
    end

    // Next-state and shifter strobes; sh_en stays low in the final frame cycle so the
    // shifter holds its last bit instead of shifting past the word.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        o_sh_load     = 1'b0;
        o_sh_en       = 1'b0;
        o_frame       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                o_sh_load     = 1'b1;
                w_bit_cnt_nxt = '0;
                w_state_nxt   = S_SHIFT;
            end
            S_SHIFT: begin
                o_frame = 1'b1;
                o_sh_en = !w_last_bit;
                if (w_last_bit) begin
                    w_bit_cnt_nxt = '0;
                    w_gap_cnt_nxt = GAP_LOAD;
                    w_state_nxt   = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Word capture, grant bookkeeping and the done pulse after the last frame bit.
    always_ff @(posedge Clock) begin
        if (!rst) begin
            r_sh_data    <= '0;
            r_grant_id   <= 1'b0;
            r_last_grant <= 1'b1;
            r_done       <= 1'b0;
        end else begin
            r_done <= (r_state == S_SHIFT) && w_last_bit;
            if (w_take0) begin
                r_sh_data    <= i_req0_data;
                r_grant_id   <= 1'b0;
                r_last_grant <= 1'b0;
            end else if (w_take1) begin
                r_sh_data    <= i_req1_data;
                r_grant_id   <= 1'b1;
                r_last_grant <= 1'b1;
            end
        end
    end

    assign o_req0_ready = w_take0;
    assign o_req1_ready = w_take1;
    assign o_sh_data    = r_sh_data;
    assign o_sh_sIn     = 1'b0;
    assign o_grant_id   = r_grant_id;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = r_done;

endmodule

// File: tb/tb_ptos_tx_sequencer.sv
// Bench for ptos_tx_sequencer: instance 0 built with GAP_CYCLES=1, instance 1 with
// GAP_CYCLES=0. A word-timeline model plus an external shifter model predict every output.
module tb_ptos_tx_sequencer;
    localparam int W  = 8;
    localparam int NI = 2;

    logic Clock = 1'b0;
    logic rst   = 1'b0;
    always #5 Clock = ~Clock;

    logic         req0_valid [NI] = '{default: 1'b0};
    logic         req1_valid [NI] = '{default: 1'b0};
    logic [W-1:0] req0_data  [NI] = '{default: '0};
    logic [W-1:0] req1_data  [NI] = '{default: '0};
    logic         req0_ready [NI];
    logic         req1_ready [NI];
    logic [W-1:0] sh_data    [NI];
    logic         sh_load    [NI];
    logic         sh_en      [NI];
    logic         sh_sIn     [NI];
    logic         frame      [NI];
    logic         grant_id   [NI];
    logic         busy       [NI];
    logic         done       [NI];

    ptos_tx_sequencer #(.WIDTH(W), .GAP_CYCLES(1)) u_dut_gap1 (
        .Clock(Clock), .rst(rst),
        .i_req0_valid(req0_valid[0]), .i_req0_data(req0_data[0]), .o_req0_ready(req0_ready[0]),
        .i_req1_valid(req1_valid[0]), .i_req1_data(req1_data[0]), .o_req1_ready(req1_ready[0]),
        .o_sh_data(sh_data[0]), .o_sh_load(sh_load[0]), .o_sh_en(sh_en[0]), .o_sh_sIn(sh_sIn[0]),
        .o_frame(frame[0]), .o_grant_id(grant_id[0]), .o_busy(busy[0]), .o_done(done[0])
    );

    ptos_tx_sequencer #(.WIDTH(W), .GAP_CYCLES(0)) u_dut_gap0 (
        .Clock(Clock), .rst(rst),
        .i_req0_valid(req0_valid[1]), .i_req0_data(req0_data[1]), .o_req0_ready(req0_ready[1]),
        .i_req1_valid(req1_valid[1]), .i_req1_data(req1_data[1]), .o_req1_ready(req1_ready[1]),
        .o_sh_data(sh_data[1]), .o_sh_load(sh_load[1]), .o_sh_en(sh_en[1]), .o_sh_sIn(sh_sIn[1]),
        .o_frame(frame[1]), .o_grant_id(grant_id[1]), .o_busy(busy[1]), .o_done(done[1])
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: cycles elapsed since the word was accepted (0 = waiting in idle).
    int           m_off  [NI];
    logic [W-1:0] m_data [NI];
    logic         m_gid  [NI];
    logic         m_last [NI];
    logic         m_done [NI];
    logic [W-1:0] shreg  [NI];
    bit           m_init = 1'b0;

    // Requester word queues: index 2*inst + requester.
    logic [W-1:0] q  [2*NI][$];
    bit           hs [2*NI] = '{default: 1'b0};

    // Logs for the directed literal checks.
    bit sout_log [NI][$];
    int acc_t    [NI][$];
    bit acc_g    [NI][$];
    int en_log   [NI][$];
    int run_log  [NI][$];
    int en_cnt   [NI] = '{default: 0};
    int run      [NI] = '{default: 0};
    bit seen     [NI] = '{default: 1'b0};

    function automatic int gap_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    function automatic int winner(input int i);
        if (req0_valid[i] && req1_valid[i]) return m_last[i] ? 0 : 1;
        if (req0_valid[i]) return 0;
        if (req1_valid[i]) return 1;
        return -1;
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cycle %0d: got %0h, expected %0h", name, i, cyc, act, exp);
        end
    endtask

    // Model update and external shifter, on the same edge the DUT samples.
    always @(posedge Clock) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NI; i++) begin
            if (sh_load[i] === 1'b1) shreg[i] <= sh_data[i];
            else if (sh_en[i] === 1'b1) shreg[i] <= {shreg[i][W-2:0], sh_sIn[i]};
            if (!rst) begin
                m_off[i]  <= 0;
                m_data[i] <= '0;
                m_gid[i]  <= 1'b0;
                m_last[i] <= 1'b1;
                m_done[i] <= 1'b0;
            end else begin
                m_done[i] <= (m_off[i] == W + 1);
                if (m_off[i] == 0) begin
                    case (winner(i))
                        0: begin
                            m_off[i] <= 1; m_data[i] <= req0_data[i];
                            m_gid[i] <= 1'b0; m_last[i] <= 1'b0;
                        end
                        1: begin
                            m_off[i] <= 1; m_data[i] <= req1_data[i];
                            m_gid[i] <= 1'b1; m_last[i] <= 1'b1;
                        end
                        default: ;
                    endcase
                end else if (m_off[i] == 1 + W + gap_of(i)) begin
                    m_off[i] <= 0;
                end else begin
                    m_off[i] <= m_off[i] + 1;
                end
            end
        end
        if (!rst) m_init <= 1'b1;
    end

    // Compare every output against the model on the falling edge.
    always @(negedge Clock) begin : cmp
        int o, k, w;
        logic fr;
        if (m_init) begin
            for (int i = 0; i < NI; i++) begin
                o  = m_off[i];
                fr = (o >= 2) && (o <= W + 1);
                k  = o - 2;
                w  = (o == 0 && rst) ? winner(i) : -1;
                chk("req0_ready", i, 32'(req0_ready[i]), 32'(w == 0));
                chk("req1_ready", i, 32'(req1_ready[i]), 32'(w == 1));
                chk("sh_load", i, 32'(sh_load[i]), 32'(o == 1));
                chk("sh_en", i, 32'(sh_en[i]), 32'(fr && (k < W - 1)));
                chk("frame", i, 32'(frame[i]), 32'(fr));
                chk("busy", i, 32'(busy[i]), 32'(o != 0));
                chk("done", i, 32'(done[i]), 32'(m_done[i]));
                chk("sh_sIn", i, 32'(sh_sIn[i]), 32'h0);
                chk("sh_data", i, 32'(sh_data[i]), 32'(m_data[i]));
                chk("grant_id", i, 32'(grant_id[i]), 32'(m_gid[i]));
                if (fr) chk("sOut", i, 32'(shreg[i][W-1]), 32'(m_data[i][W-1-k]));

                if (frame[i] === 1'b1) sout_log[i].push_back(shreg[i][W-1]);
                hs[2*i]   = (req0_valid[i] && req0_ready[i] === 1'b1);
                hs[2*i+1] = (req1_valid[i] && req1_ready[i] === 1'b1);
                if (hs[2*i])   begin acc_t[i].push_back(cyc); acc_g[i].push_back(1'b0); end
                if (hs[2*i+1]) begin acc_t[i].push_back(cyc); acc_g[i].push_back(1'b1); end
                if (sh_en[i] === 1'b1) en_cnt[i]++;
                if (done[i] === 1'b1) begin en_log[i].push_back(en_cnt[i]); en_cnt[i] = 0; end
                if (frame[i] === 1'b1) begin
                    if (seen[i] && run[i] > 0) run_log[i].push_back(run[i]);
                    run[i]  = 0;
                    seen[i] = 1'b1;
                end else begin
                    run[i]++;
                end
                if (!rst) begin en_cnt[i] = 0; run[i] = 0; seen[i] = 1'b0; end
            end
        end
    end

    // Requester driver: hold valid/data until the handshake seen on the previous falling edge.
    initial begin
        forever begin
            @(posedge Clock);
            #1;
            for (int j = 0; j < 2*NI; j++) begin
                if (hs[j] && q[j].size() > 0) void'(q[j].pop_front());
            end
            for (int i = 0; i < NI; i++) begin
                req0_valid[i] = (q[2*i].size() > 0);
                req0_data[i]  = (q[2*i].size() > 0) ? q[2*i][0] : '0;
                req1_valid[i] = (q[2*i+1].size() > 0);
                req1_data[i]  = (q[2*i+1].size() > 0) ? q[2*i+1][0] : '0;
            end
        end
    end

    task automatic wait_idle(input int i, input int budget);
        int n;
        n = 0;
        @(negedge Clock);
        while (!(q[2*i].size() == 0 && q[2*i+1].size() == 0 && !req0_valid[i] && !req1_valid[i]
                 && busy[i] === 1'b0 && done[i] === 1'b0) && n < budget) begin
            @(negedge Clock);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_idle inst%0d: still busy after %0d cycles, required idle", i, budget);
        end
        @(posedge Clock);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] val;
        int n;
        int s;

        // 1) reset held two cycles with both requesters valid
        rst = 1'b0;
        q[0].push_back(8'h85);
        q[1].push_back(8'h3C);
        repeat (2) @(posedge Clock);
        #1;
        chk("t1_rst_ready0", 0, 32'(req0_ready[0]), 32'h0);
        chk("t1_rst_ready1", 0, 32'(req1_ready[0]), 32'h0);
        chk("t1_rst_load", 0, 32'(sh_load[0]), 32'h0);
        chk("t1_rst_frame", 0, 32'(frame[0]), 32'h0);
        chk("t1_rst_busy", 0, 32'(busy[0]), 32'h0);
        chk("t1_rst_done", 0, 32'(done[0]), 32'h0);
        rst = 1'b1;
        wait_idle(0, 200);

        // 2) first word 0x85 from req0 wins the reset tie
        val = '0;
        for (int b = 0; b < W; b++) val = {val[W-2:0], sout_log[0][b]};
        chk("t2_sout_bits", 0, 32'(val), 32'h85);
        chk("t2_grant", 0, 32'(acc_g[0][0]), 32'h0);
        chk("t2_second_grant", 0, 32'(acc_g[0][1]), 32'h1);
        chk("t2_spacing", 0, acc_t[0][1] - acc_t[0][0], 11);

        // 3) contention, both valid held for four words
        q[0].push_back(8'hAA); q[1].push_back(8'h55);
        q[0].push_back(8'hAA); q[1].push_back(8'h55);
        wait_idle(0, 300);
        for (int k = 2; k < 6; k++) chk("t3_grant_order", 0, 32'(acc_g[0][k]), 32'(k % 2));
        for (int k = 2; k < 5; k++) chk("t3_spacing", 0, acc_t[0][k+1] - acc_t[0][k], 11);
        chk("t3_accept_count", 0, acc_t[0].size(), 6);

        // 4) sh_en cycles per word and frame-low run between back-to-back words
        for (int k = 0; k < 6; k++) chk("t4_en_cycles", 0, en_log[0][k], 7);
        chk("t4_frame_gap", 0, run_log[0][0], 3);
        for (int k = 2; k < 5; k++) chk("t4_frame_gap", 0, run_log[0][k], 3);

        // 5) reset in frame cycle 3 of 0xD2, then 0x11
        q[0].push_back(8'hD2);
        n = 0;
        while (sh_load[0] !== 1'b1 && n < 50) begin @(posedge Clock); #1; n++; end
        chk("t5_load_seen", 0, 32'(n < 50), 32'h1);
        repeat (4) begin @(posedge Clock); #1; end
        chk("t5_in_frame", 0, 32'(frame[0]), 32'h1);
        rst = 1'b0;
        @(posedge Clock); #1;
        chk("t5_frame_drop", 0, 32'(frame[0]), 32'h0);
        chk("t5_busy_drop", 0, 32'(busy[0]), 32'h0);
        rst = 1'b1;
        repeat (3) begin @(posedge Clock); #1; end
        chk("t5_no_done", 0, en_log[0].size(), 6);
        q[0].push_back(8'h11);
        wait_idle(0, 200);
        s = sout_log[0].size() - W;
        val = '0;
        for (int b = 0; b < W; b++) val = {val[W-2:0], sout_log[0][s + b]};
        chk("t5_next_word", 0, 32'(val), 32'h11);
        chk("t5_done_after", 0, en_log[0].size(), 7);

        // 6) GAP_CYCLES=0 instance, back-to-back req1 words
        q[3].push_back(8'hFF);
        q[3].push_back(8'h00);
        wait_idle(1, 200);
        chk("t6_spacing", 1, acc_t[1][1] - acc_t[1][0], 10);
        chk("t6_grant", 1, 32'(acc_g[1][0]), 32'h1);
        chk("t6_frame_gap", 1, run_log[1][0], 2);
        chk("t6_en_cycles", 1, en_log[1][0], 7);
        chk("t6_en_cycles", 1, en_log[1][1], 7);

        // randomized traffic on both instances with occasional reset pulses
        for (int c = 0; c < 3000; c++) begin
            @(posedge Clock);
            #1;
            for (int j = 0; j < 2*NI; j++) begin
                if (q[j].size() < 3 && $urandom_range(0, 9) == 0) q[j].push_back(8'($urandom));
            end
            rst = ($urandom_range(0, 299) != 0);
        end
        rst = 1'b1;
        wait_idle(0, 2000);
        wait_idle(1, 2000);
        for (int j = 0; j < 2*NI; j++) chk("drain_queue", j / 2, q[j].size(), 0);
        for (int i = 0; i < NI; i++) begin
            foreach (en_log[i][k]) chk("en_cycles_all", i, en_log[i][k], 7);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
